// File: rtl/pmod_probe_serializer.sv
// Snapshot FIFO plus beat serializer that streams debug words onto byte-wide PMOD lanes.
// Define PROBE_CHECKSUM_EN to append an XOR checksum beat after each frame's data beats.
module pmod_probe_serializer #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    parameter int DIV      = 125
) (
    input  logic                       sysclk,
    input  logic                       btn,
    input  logic                       cap_valid,
    input  logic [CHANNELS*DATA_W-1:0] cap_data,
    output logic                       cap_ready,
    output logic [8*LANES-1:0]         pmod_out,
    output logic                       frame_start,
    output logic                       busy,
    output logic [7:0]                 drop_cnt,
    output logic [3:0]                 led
);
    localparam int BUS_W = 8 * LANES;
    localparam int BPC   = (DATA_W + BUS_W - 1) / BUS_W;
    localparam int PAD_W = BPC * BUS_W;
    localparam int NBD   = CHANNELS * BPC;
`ifdef PROBE_CHECKSUM_EN
    localparam int NB    = NBD + 1;
`else
    localparam int NB    = NBD;
`endif
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int DW    = $clog2(DIV);
    localparam int BW    = $clog2(NB + 1);
    localparam int IW    = (NBD > 1) ? $clog2(NBD) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [CHANNELS*DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic             push, pop, full, drop_nz, heartbeat, last_tick;
    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    beat_idx;
    logic [IW-1:0]    nxt_idx;
    logic [BUS_W-1:0] head_beats  [NBD];
    logic [BUS_W-1:0] frame_beats [NBD];
    logic [PAD_W-1:0] padded;
`ifdef PROBE_CHECKSUM_EN
    logic [BUS_W-1:0] csum;
`endif

    assign push      = cap_valid && cap_ready;
    assign last_tick = (div_cnt == DW'(DIV - 1));
    assign pop       = (count != '0) && ((state == IDLE) || ((state == GAP) && last_tick));
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign nxt_idx   = IW'(beat_idx + BW'(1));
    assign led       = {heartbeat, drop_nz, full, busy};

    // Head snapshot cut into beats: channel 0 first, most significant chunk first.
    always_comb begin
        padded = '0;
        for (int i = 0; i < NBD; i++) head_beats[i] = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            padded = '0;
            padded[DATA_W-1:0] = mem[rd_ptr][ch*DATA_W +: DATA_W];
            for (int c = 0; c < BPC; c++)
                head_beats[ch*BPC + c] = padded[(BPC-1-c)*BUS_W +: BUS_W];
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= cap_data;
        if (pop)  frame_beats <= head_beats;
    end

    always_ff @(posedge sysclk or posedge btn) begin
        if (btn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            cap_ready <= 1'b1;
            drop_cnt  <= '0;
            drop_nz   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count     <= count_nxt;
            full      <= (count_nxt == CW'(DEPTH));
            cap_ready <= (count_nxt != CW'(DEPTH));
            if (cap_valid && !cap_ready) begin
                drop_nz <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // state | meaning
    // IDLE  | nothing to send, pmod_out low
    // SEND  | holding data (or checksum) beat beat_idx for DIV cycles
    // GAP   | all-zero separator beat closing a frame
    always_ff @(posedge sysclk or posedge btn) begin
        if (btn) begin
            state       <= IDLE;
            div_cnt     <= '0;
            beat_idx    <= '0;
            pmod_out    <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            heartbeat   <= 1'b0;
`ifdef PROBE_CHECKSUM_EN
            csum        <= '0;
`endif
        end else if (pop) begin
            state       <= SEND;
            div_cnt     <= '0;
            beat_idx    <= '0;
            pmod_out    <= head_beats[0];
            frame_start <= 1'b1;
            busy        <= 1'b1;
            if (state == GAP) heartbeat <= ~heartbeat;
`ifdef PROBE_CHECKSUM_EN
            csum        <= head_beats[0];
`endif
        end else begin
            case (state)
                IDLE: busy <= (count_nxt != '0);
                SEND: begin
                    if (!last_tick) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt     <= '0;
                        frame_start <= 1'b0;
                        if (beat_idx == BW'(NB - 1)) begin
                            state    <= GAP;
                            pmod_out <= '0;
                        end else begin
                            beat_idx <= beat_idx + BW'(1);
`ifdef PROBE_CHECKSUM_EN
                            if (beat_idx == BW'(NBD - 1)) begin
                                pmod_out <= csum;
                            end else begin
                                pmod_out <= frame_beats[nxt_idx];
                                csum     <= csum ^ frame_beats[nxt_idx];
                            end
`else
                            pmod_out <= frame_beats[nxt_idx];
`endif
                        end
                    end
                end
                GAP: begin
                    if (!last_tick) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt   <= '0;
                        heartbeat <= ~heartbeat;
                        state     <= IDLE;
                        busy      <= (count_nxt != '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
